// File: rtl/gcm_aes_seq_ctrl.sv
// rtl/gcm_aes_seq_ctrl.sv - message sequencer driving one gcm_aes core
// Purpose: walks a GCM message through AAD load, key setup wait, credit-guarded
//   plaintext issue and tag return; ciphertext is buffered in a small FIFO.
// Ports:
//   clk, rst                      clock, async active-high reset
//   i_start/i_aad/i_aad_blocks    message start, AAD blocks and count
//   i_pt_blocks/i_last_bytes      plaintext block count, valid bytes of last block
//   o_busy                        high outside IDLE
//   i_pt_valid/o_pt_ready/i_pt_data   plaintext block stream in
//   o_ct_valid/i_ct_ready/o_ct_data   ciphertext block stream out
//   o_tag_valid/i_tag_ack/o_tag   tag handshake
//   o_core_*                      strobes, data and bit lengths to the core
//   i_core_ct_ready/i_core_ct     ciphertext return from the core
//   i_core_tag_ready/i_core_tag   tag return from the core
module gcm_aes_seq_ctrl #(
  parameter int MAX_AAD_BLK   = 4,
  parameter int CNT_W         = 16,
  parameter int FIFO_DEPTH    = 4,
  parameter int KEY_SETUP_CYC = 14
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_start,
  input  logic [MAX_AAD_BLK*128-1:0]       i_aad,
  input  logic [$clog2(MAX_AAD_BLK+1)-1:0] i_aad_blocks,
  input  logic [CNT_W-1:0]                 i_pt_blocks,
  input  logic [3:0]                       i_last_bytes,
  output logic                             o_busy,
  input  logic                             i_pt_valid,
  output logic                             o_pt_ready,
  input  logic [127:0]                     i_pt_data,
  output logic                             o_ct_valid,
  input  logic                             i_ct_ready,
  output logic [127:0]                     o_ct_data,
  output logic                             o_tag_valid,
  input  logic                             i_tag_ack,
  output logic [127:0]                     o_tag,
  output logic                             o_core_new_instance,
  output logic                             o_core_pt_instance,
  output logic [127:0]                     o_core_aad,
  output logic [127:0]                     o_core_pt,
  output logic [63:0]                      o_core_aad_size,
  output logic [63:0]                      o_core_pt_size,
  input  logic                             i_core_ct_ready,
  input  logic [127:0]                     i_core_ct,
  input  logic                             i_core_tag_ready,
  input  logic [127:0]                     i_core_tag
);
  localparam int AW  = $clog2(MAX_AAD_BLK+1);
  localparam int FW  = $clog2(FIFO_DEPTH+1);
  localparam int FW1 = FW + 1;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int KW  = $clog2(KEY_SETUP_CYC+MAX_AAD_BLK+2);
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH-1);
  localparam logic [FW:0]   DEPTH_C  = FW1'(FIFO_DEPTH);
  localparam logic [KW-1:0] KEY_LAST = KW'(KEY_SETUP_CYC-1);

  typedef enum logic [2:0] {S_IDLE, S_AAD, S_KEY_WAIT, S_PT, S_TAG_WAIT, S_TAG_OUT} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] aad_n_q, aad_n_d, aad_idx_q, aad_idx_d;
  logic [KW-1:0] key_cnt_q, key_cnt_d;
  logic [CNT_W-1:0] pt_n_q, pt_n_d, issued_q, issued_d, returned_q, returned_d;
  logic [4:0]    lb_q, lb_d;
  logic [FW-1:0] inflight_q, inflight_d, fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [127:0]  tag_q, tag_d;
  logic [63:0]   aad_size_q, aad_size_d, pt_size_q, pt_size_d;
  logic [127:0]  fifo_mem_q [FIFO_DEPTH];

  logic [127:0]  last_mask, ct_push_data;
  logic [FW:0]   credit_sum;
  logic [4:0]    lb_in;
  logic          pt_hs, pt_last, ct_push, ct_pop;

  always_comb begin
    last_mask = '0;
    for (int b = 0; b < 16; b++) begin
      last_mask[b*8 +: 8] = (5'(b) < lb_q) ? 8'hff : 8'h00;
    end
    lb_in      = (i_last_bytes == 4'd0) ? 5'd16 : {1'b0, i_last_bytes};
    credit_sum = {1'b0, fifo_cnt_q} + {1'b0, inflight_q};
    // Blocks already in the FIFO plus blocks inside the core never exceed
    // FIFO_DEPTH, so a returning block always has a slot.
    o_pt_ready = (state_q == S_PT) && (issued_q < pt_n_q) && (credit_sum < DEPTH_C);
    pt_hs      = i_pt_valid && o_pt_ready;
    pt_last    = (issued_q == pt_n_q - CNT_W'(1));
    ct_push    = i_core_ct_ready && (inflight_q != '0);
    ct_push_data = (returned_q == pt_n_q - CNT_W'(1)) ? (i_core_ct & last_mask) : i_core_ct;
    ct_pop     = (fifo_cnt_q != '0) && i_ct_ready;

    o_busy              = (state_q != S_IDLE);
    o_core_new_instance = (state_q == S_AAD) && (aad_idx_q == '0);
    o_core_aad          = ((state_q == S_AAD) && (aad_idx_q < aad_n_q)) ?
                          i_aad[int'(aad_idx_q)*128 +: 128] : '0;
    o_core_pt_instance  = pt_hs && (issued_q == '0);
    o_core_pt           = pt_hs ? (pt_last ? (i_pt_data & last_mask) : i_pt_data) : '0;
    o_ct_valid          = (fifo_cnt_q != '0);
    o_ct_data           = o_ct_valid ? fifo_mem_q[rd_ptr_q] : '0;
    o_tag_valid         = (state_q == S_TAG_OUT) && (fifo_cnt_q == '0) && (inflight_q == '0);
    o_tag               = tag_q;
    o_core_aad_size     = aad_size_q;
    o_core_pt_size      = pt_size_q;
  end

  always_comb begin
    state_d    = state_q;
    aad_n_d    = aad_n_q;
    aad_idx_d  = aad_idx_q;
    key_cnt_d  = key_cnt_q;
    pt_n_d     = pt_n_q;
    lb_d       = lb_q;
    tag_d      = tag_q;
    aad_size_d = aad_size_q;
    pt_size_d  = pt_size_q;
    issued_d   = issued_q + CNT_W'(pt_hs);
    returned_d = returned_q + CNT_W'(ct_push);
    wr_ptr_d   = ct_push ? ((wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d   = ct_pop ? ((rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    case ({pt_hs, ct_push})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
    case ({ct_push, ct_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    case (state_q)
      S_IDLE: if (i_start) begin
        state_d    = S_AAD;
        aad_n_d    = i_aad_blocks;
        aad_idx_d  = '0;
        key_cnt_d  = '0;
        pt_n_d     = i_pt_blocks;
        lb_d       = lb_in;
        issued_d   = '0;
        returned_d = '0;
        aad_size_d = 64'({i_aad_blocks, 7'b0});
        pt_size_d  = (i_pt_blocks == '0) ? 64'd0 :
                     64'({i_pt_blocks - CNT_W'(1), 7'b0}) + 64'({lb_in, 3'b0});
      end
      S_AAD: begin
        // Key setup time is measured from the new_instance cycle, so the
        // counter already runs while AAD blocks go out.
        key_cnt_d = key_cnt_q + 1'b1;
        aad_idx_d = aad_idx_q + 1'b1;
        if ((aad_n_q == '0) || (aad_idx_q == aad_n_q - AW'(1))) state_d = S_KEY_WAIT;
      end
      S_KEY_WAIT: begin
        key_cnt_d = key_cnt_q + 1'b1;
        if (key_cnt_q >= KEY_LAST) state_d = (pt_n_q == '0) ? S_TAG_WAIT : S_PT;
      end
      S_PT:       if (pt_hs && pt_last) state_d = S_TAG_WAIT;
      S_TAG_WAIT: state_d = S_TAG_WAIT;
      S_TAG_OUT: if (o_tag_valid && i_tag_ack) begin
        state_d    = S_IDLE;
        aad_size_d = '0;
        pt_size_d  = '0;
      end
      default:    state_d = S_IDLE;
    endcase
    if (i_core_tag_ready && ((state_q == S_KEY_WAIT) || (state_q == S_PT) || (state_q == S_TAG_WAIT))) begin
      tag_d   = i_core_tag;
      state_d = S_TAG_OUT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      aad_n_q    <= '0;
      aad_idx_q  <= '0;
      key_cnt_q  <= '0;
      pt_n_q     <= '0;
      lb_q       <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tag_q      <= '0;
      aad_size_q <= '0;
      pt_size_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      aad_n_q    <= aad_n_d;
      aad_idx_q  <= aad_idx_d;
      key_cnt_q  <= key_cnt_d;
      pt_n_q     <= pt_n_d;
      lb_q       <= lb_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tag_q      <= tag_d;
      aad_size_q <= aad_size_d;
      pt_size_q  <= pt_size_d;
      if (ct_push) fifo_mem_q[wr_ptr_q] <= ct_push_data;
    end
  end
endmodule

// File: tb/tb_gcm_aes_seq_ctrl.sv
// tb/tb_gcm_aes_seq_ctrl.sv - scoreboard bench for gcm_aes_seq_ctrl with a core model
module tb_gcm_aes_seq_ctrl;
  localparam int FIFO_DEPTH = 4;
  localparam int KEY_SETUP  = 14;
  localparam logic [127:0] PAD0 = 128'h0388dace60b6a392f328c2b971b2fe78;

  logic clk = 1'b0;
  logic rst;
  logic i_start, i_pt_valid, i_ct_ready, i_tag_ack, i_core_ct_ready, i_core_tag_ready;
  logic [511:0] i_aad;
  logic [2:0]   i_aad_blocks;
  logic [15:0]  i_pt_blocks;
  logic [3:0]   i_last_bytes;
  logic [127:0] i_pt_data, i_core_ct, i_core_tag;
  logic o_busy, o_pt_ready, o_ct_valid, o_tag_valid, o_core_new_instance, o_core_pt_instance;
  logic [127:0] o_ct_data, o_tag, o_core_aad, o_core_pt;
  logic [63:0]  o_core_aad_size, o_core_pt_size;

  always #5 clk = ~clk;

  gcm_aes_seq_ctrl dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_aad(i_aad), .i_aad_blocks(i_aad_blocks),
    .i_pt_blocks(i_pt_blocks), .i_last_bytes(i_last_bytes), .o_busy(o_busy),
    .i_pt_valid(i_pt_valid), .o_pt_ready(o_pt_ready), .i_pt_data(i_pt_data),
    .o_ct_valid(o_ct_valid), .i_ct_ready(i_ct_ready), .o_ct_data(o_ct_data),
    .o_tag_valid(o_tag_valid), .i_tag_ack(i_tag_ack), .o_tag(o_tag),
    .o_core_new_instance(o_core_new_instance), .o_core_pt_instance(o_core_pt_instance),
    .o_core_aad(o_core_aad), .o_core_pt(o_core_pt), .o_core_aad_size(o_core_aad_size),
    .o_core_pt_size(o_core_pt_size), .i_core_ct_ready(i_core_ct_ready), .i_core_ct(i_core_ct),
    .i_core_tag_ready(i_core_tag_ready), .i_core_tag(i_core_tag)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  typedef struct {logic [127:0] d; int due;} ret_t;
  logic [127:0] exp_q[$];
  ret_t         pipe_q[$];

  int cyc = 0;
  int m_aad_n, m_pt_n, m_lb, pt_idx, core_ret, ni_cyc, ni_count, ap, ct_mode, release_cyc;
  logic [511:0] m_aad;
  logic [127:0] m_tag;
  logic [127:0] pt_src [16];
  bit start_req, tag_sent, done, tag_seen, pt_taken, spurious;

  function automatic logic [127:0] pad(input int k);
    return PAD0 ^ {32'(k), 96'h0};
  endfunction

  function automatic logic [127:0] bmask(input int lb);
    logic [127:0] m = '0;
    int n = (lb == 0) ? 16 : lb;
    for (int b = 0; b < n; b++) m[b*8 +: 8] = 8'hff;
    return m;
  endfunction

  function automatic logic [15:0] outs_or();
    return {6'd0, o_busy, o_pt_ready, o_ct_valid, o_tag_valid, o_core_new_instance,
            o_core_pt_instance, |o_ct_data, |o_tag, |{o_core_aad, o_core_pt},
            |{o_core_aad_size, o_core_pt_size}};
  endfunction

  task automatic drive();
    i_start = start_req;
    if (start_req) begin
      i_aad        = m_aad;
      i_aad_blocks = 3'(m_aad_n);
      i_pt_blocks  = 16'(m_pt_n);
      i_last_bytes = 4'(m_lb);
    end
    start_req = 1'b0;
    if (!i_pt_valid || pt_taken) begin
      i_pt_valid = 1'b0;
      if (pt_idx < m_pt_n && $urandom_range(0, 3) != 0) begin
        i_pt_valid = 1'b1;
        i_pt_data  = pt_src[pt_idx];
      end
    end
    pt_taken = 1'b0;
    i_core_ct_ready = 1'b0;
    if (pipe_q.size() > 0 && pipe_q[0].due <= cyc) begin
      i_core_ct_ready = 1'b1;
      i_core_ct = pipe_q[0].d;
      void'(pipe_q.pop_front());
      core_ret++;
    end else if (spurious && ni_count > 0 && cyc == ni_cyc + 5) begin
      i_core_ct_ready = 1'b1;
      i_core_ct = 128'hbad0bad0bad0bad0bad0bad0bad0bad0;
    end
    i_core_tag_ready = 1'b0;
    if (!tag_sent && ni_count > 0 && core_ret == m_pt_n && !i_core_ct_ready &&
        pipe_q.size() == 0 && cyc >= ni_cyc + KEY_SETUP + 2) begin
      i_core_tag_ready = 1'b1;
      i_core_tag = m_tag;
      tag_sent = 1'b1;
    end
    case (ct_mode)
      0:       i_ct_ready = ($urandom_range(0, 3) != 0);
      1:       i_ct_ready = 1'b1;
      default: i_ct_ready = (cyc >= release_cyc);
    endcase
    if (ct_mode == 2 && cyc == release_cyc) begin
      check_eq("bp_issued", pt_idx, FIFO_DEPTH);
      check_eq("bp_ready_low", o_pt_ready, 0);
    end
    i_tag_ack = tag_seen;
  endtask

  task automatic sample();
    int k;
    logic lst;
    logic [127:0] mpt;
    cyc++;
    if (ap >= 0 && ap < ((m_aad_n == 0) ? 1 : m_aad_n)) begin
      check_eq($sformatf("aad%0d", ap), o_core_aad, (ap < m_aad_n) ? m_aad[ap*128 +: 128] : 128'd0);
      check_eq("new_inst", o_core_new_instance, ap == 0);
      ap++;
    end
    if (i_start) begin
      check_eq("idle_before_start", o_busy, 0);
      ap = 0;
    end
    if (o_core_new_instance) begin
      ni_count++;
      ni_cyc = cyc;
    end
    if (i_pt_valid && o_pt_ready) begin
      k   = pt_idx;
      lst = (k == m_pt_n - 1);
      mpt = lst ? (i_pt_data & bmask(m_lb)) : i_pt_data;
      check_eq("core_pt", o_core_pt, mpt);
      check_eq("pt_inst", o_core_pt_instance, k == 0);
      if (k == 0) check_eq("key_setup", (cyc - ni_cyc) >= KEY_SETUP, 1);
      exp_q.push_back(lst ? ((i_pt_data ^ pad(k)) & bmask(m_lb)) : (i_pt_data ^ pad(k)));
      pipe_q.push_back('{o_core_pt ^ pad(k), cyc + 3});
      pt_idx++;
      pt_taken = 1'b1;
    end
    if (o_ct_valid && i_ct_ready) begin
      if (exp_q.size() == 0) check_eq("ct_unexpected", o_ct_valid, 0);
      else check_eq("ct", o_ct_data, exp_q.pop_front());
    end
    if (o_tag_valid && !tag_seen) begin
      tag_seen = 1'b1;
      check_eq("tag_fifo_empty", o_ct_valid, 0);
    end
    if (o_tag_valid && i_tag_ack) begin
      check_eq("tag", o_tag, m_tag);
      check_eq("ct_all_out", exp_q.size(), 0);
      done = 1'b1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    drive();
    #1;
    sample();
  endtask

  task automatic run_msg(input int aad_n, input int pt_n, input int lb, input logic [127:0] tag,
                         input int mode, input bit zero_pt, input bit spur, input bit abort);
    int t0;
    logic [63:0] exp_pt_size;
    m_aad_n = aad_n; m_pt_n = pt_n; m_lb = lb; m_tag = tag; ct_mode = mode; spurious = spur;
    for (int i = 0; i < 16; i++) m_aad[i*32 +: 32] = zero_pt ? 32'd0 : $urandom;
    for (int i = 0; i < 16; i++) pt_src[i] = zero_pt ? 128'd0 : {$urandom, $urandom, $urandom, $urandom};
    pt_idx = 0; core_ret = 0; ni_count = 0; ni_cyc = 0; ap = -1;
    tag_sent = 0; done = 0; tag_seen = 0; pt_taken = 0;
    exp_q.delete();
    pipe_q.delete();
    release_cyc = cyc + 60;
    start_req = 1'b1;
    t0 = cyc;
    tick();
    tick();
    exp_pt_size = (pt_n == 0) ? 64'd0 : 64'((pt_n - 1) * 128 + ((lb == 0) ? 16 : lb) * 8);
    check_eq("busy", o_busy, 1);
    check_eq("aad_size", o_core_aad_size, 64'(aad_n * 128));
    check_eq("pt_size", o_core_pt_size, exp_pt_size);
    while (!done && (cyc - t0) < 3000) begin
      tick();
      if (abort && pt_idx >= 2) begin
        @(negedge clk);
        rst = 1'b1;
        i_pt_valid = 0; i_core_ct_ready = 0; i_core_tag_ready = 0; i_start = 0;
        #1;
        check_eq("abort_outs_zero", outs_or(), 0);
        @(negedge clk);
        #1;
        check_eq("abort_fifo_empty", o_ct_valid, 0);
        rst = 1'b0;
        exp_q.delete();
        pipe_q.delete();
        m_pt_n = 0;
        return;
      end
    end
    check_eq("msg_done", done, 1);
    check_eq("ni_count", ni_count, 1);
    tick();
    check_eq("idle_after", o_busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    i_start = 0; i_pt_valid = 0; i_ct_ready = 0; i_tag_ack = 0;
    i_core_ct_ready = 0; i_core_tag_ready = 0;
    i_aad = '0; i_aad_blocks = '0; i_pt_blocks = '0; i_last_bytes = '0;
    i_pt_data = '0; i_core_ct = '0; i_core_tag = '0;
    m_pt_n = 0; m_aad_n = 0; ap = -1; start_req = 0; pt_taken = 0; tag_seen = 0;
    spurious = 0; ct_mode = 1; tag_sent = 1; ni_count = 0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("reset_outs_zero", outs_or(), 0);
    rst = 1'b0;

    run_msg(0, 0, 0, 128'h58e2fccefa7e3061367f1d57a4e7455a, 1, 1'b1, 1'b1, 1'b0);
    run_msg(0, 1, 0, 128'hab6e47d42cec13bdf53a67b21257bddf, 1, 1'b1, 1'b0, 1'b0);
    run_msg(2, 8, 0, 128'h11112222333344445555666677778888, 2, 1'b0, 1'b0, 1'b0);
    run_msg(3, 2, 4, 128'h0123456789abcdef0f1e2d3c4b5a6978, 0, 1'b0, 1'b0, 1'b0);
    run_msg(1, 4, 0, 128'hdeaddeaddeaddeaddeaddeaddeaddead, 1, 1'b0, 1'b0, 1'b1);
    run_msg(1, 3, 9, 128'hcafef00dcafef00dcafef00dcafef00d, 0, 1'b0, 1'b0, 1'b0);
    for (int t = 0; t < 3; t++) begin
      run_msg($urandom_range(0, 4), $urandom_range(1, 7), $urandom_range(0, 15),
              {$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
